// File: rtl/fbuf_bank_pkg.sv
// Frame-buffer bank manager shared types: bank states,
// configuration checks and bank search helpers.
package fbuf_bank_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } bank_state_t;

  localparam int MIN_BANKS = 2;
  localparam int MAX_BANKS = 4;
  localparam int IDX_W     = 2;

  // One 2-bit state per bank, sized for the largest build.
  typedef logic [MAX_BANKS-1:0][1:0] bank_vec_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } bank_find_t;

  function automatic bit cfg_ok(int n, int w);
    return (n >= MIN_BANKS) && (n <= MAX_BANKS)
        && ((1 << w) >= n);
  endfunction

  function automatic bank_vec_t reset_vec(int n);
    bank_vec_t v;
    for (int i = 0; i < MAX_BANKS; i++) begin
      v[i] = (i == n - 1) ? READING : FREE;
    end
    return v;
  endfunction

  // Lowest-index bank of the given state; banks >= n ignored.
  function automatic bank_find_t find_bank(
    bank_vec_t st, int n, bank_state_t s);
    bank_find_t r;
    r = '0;
    for (int i = MAX_BANKS - 1; i >= 0; i--) begin
      if (i < n && st[i] == s) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/load_pulse_stretch.sv
// Retriggerable pulse stretcher: trig_i starts (or restarts)
// a pulse_o high for LOAD_CYCLES clocks. Ports: clk, rst, trig_i, pulse_o.
module load_pulse_stretch #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic pulse_o
);

  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 15) begin : g_bad
    $error("load_pulse_stretch: LOAD_CYCLES out of range");
  end

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig_i) begin
      cnt_d = 4'(LOAD_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q != 4'd0);

endmodule

// File: rtl/fbuf_bank_manager.sv
// N-bank frame-buffer manager: hands banks between camera writer and
// LCD reader tear-free; drives bank select, address window, reload pulses
// and drop/repeat/abort statistics. Inputs: clk, rst, frame_valid (async),
// frame_write_done, frame_read_done. Outputs: wr/rd bank, addr, max_addr,
// load, wr_busy, frames_dropped/repeated/aborted.
import fbuf_bank_pkg::*;

module fbuf_bank_manager #(
  parameter int NUM_BANKS   = 3,
  parameter int BANK_W      = 2,
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 737280,
  parameter int LOAD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_valid,
  input  logic                     frame_write_done,
  input  logic                     frame_read_done,
  output logic [BANK_W-1:0]        wr_bank,
  output logic [BANK_W-1:0]        rd_bank,
  output logic [BANK_W+ADDR_W-1:0] wr_addr,
  output logic [BANK_W+ADDR_W-1:0] wr_max_addr,
  output logic [BANK_W+ADDR_W-1:0] rd_addr,
  output logic [BANK_W+ADDR_W-1:0] rd_max_addr,
  output logic                     wr_load,
  output logic                     rd_load,
  output logic                     wr_busy,
  output logic [CNT_W-1:0]         frames_dropped,
  output logic [CNT_W-1:0]         frames_repeated,
  output logic [CNT_W-1:0]         frames_aborted
);

  if (!cfg_ok(NUM_BANKS, BANK_W)) begin : g_cfg_bad
    $error("fbuf_bank_manager: bad NUM_BANKS/BANK_W");
  end

  localparam bank_vec_t        ST_RST = reset_vec(NUM_BANKS);
  localparam logic [IDX_W-1:0] RD_RST = IDX_W'(NUM_BANKS - 1);

  function automatic logic [CNT_W-1:0] sat_add(
    logic [CNT_W-1:0] c, logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Synchroniser (s1,s2), edge history (s3), registered start pulse.
  logic       s1_q, s2_q, s3_q;
  logic       wr_start_q;

  bank_vec_t        st_q, st1, st2, st_d;
  logic [IDX_W-1:0] wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] abort_q, abort_d;
  logic             wr_fire, rd_fire;
  logic [1:0]       drop_inc;
  logic             rep_inc, abort_inc;

  bank_find_t f_wr, f_rdy, f_rdy2, f_rdg2;
  bank_find_t f_wr3, f_free3, f_rdy3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      wr_start_q <= 1'b0;
      st_q       <= ST_RST;
      wr_bank_q  <= '0;
      rd_bank_q  <= RD_RST;
      drop_q     <= '0;
      rep_q      <= '0;
      abort_q    <= '0;
    end else begin
      s1_q       <= frame_valid;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      wr_start_q <= s2_q & ~s3_q;
      st_q       <= st_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      drop_q     <= drop_d;
      rep_q      <= rep_d;
      abort_q    <= abort_d;
    end
  end

  assign f_wr  = find_bank(st_q, NUM_BANKS, WRITING);
  assign f_rdy = find_bank(st_q, NUM_BANKS, READY);

  // Commit, swap and start are chained so each sees the previous.
  always_comb begin
    st1       = st_q;
    drop_inc  = 2'd0;
    rep_inc   = 1'b0;
    abort_inc = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;

    if (frame_write_done && f_wr.hit) begin
      if (f_rdy.hit) begin
        st1[f_rdy.idx] = FREE;
        drop_inc       = drop_inc + 2'd1;
      end
      st1[f_wr.idx] = READY;
    end

    st2    = st1;
    f_rdy2 = find_bank(st1, NUM_BANKS, READY);
    f_rdg2 = find_bank(st1, NUM_BANKS, READING);
    if (frame_read_done) begin
      rd_fire = 1'b1;
      if (f_rdy2.hit) begin
        if (f_rdg2.hit) begin
          st2[f_rdg2.idx] = FREE;
        end
        st2[f_rdy2.idx] = READING;
        rd_bank_d       = f_rdy2.idx;
      end else begin
        rep_inc = 1'b1;
      end
    end

    st_d    = st2;
    f_wr3   = find_bank(st2, NUM_BANKS, WRITING);
    f_free3 = find_bank(st2, NUM_BANKS, FREE);
    f_rdy3  = find_bank(st2, NUM_BANKS, READY);
    if (wr_start_q) begin
      wr_fire = 1'b1;
      priority case (1'b1)
        f_wr3.hit: begin
          wr_bank_d = f_wr3.idx;
          abort_inc = 1'b1;
        end
        f_free3.hit: begin
          st_d[f_free3.idx] = WRITING;
          wr_bank_d         = f_free3.idx;
        end
        f_rdy3.hit: begin
          st_d[f_rdy3.idx] = WRITING;
          wr_bank_d        = f_rdy3.idx;
          drop_inc         = drop_inc + 2'd1;
        end
        default: ;
      endcase
    end

    drop_d  = sat_add(drop_q, drop_inc);
    rep_d   = sat_add(rep_q, {1'b0, rep_inc});
    abort_d = sat_add(abort_q, {1'b0, abort_inc});
  end

  load_pulse_stretch #(
    .LOAD_CYCLES(LOAD_CYCLES)
  ) u_wr_load (
    .clk    (clk),
    .rst    (rst),
    .trig_i (wr_fire),
    .pulse_o(wr_load)
  );

  load_pulse_stretch #(
    .LOAD_CYCLES(LOAD_CYCLES)
  ) u_rd_load (
    .clk    (clk),
    .rst    (rst),
    .trig_i (rd_fire),
    .pulse_o(rd_load)
  );

  always_comb begin
    wr_bank         = BANK_W'(wr_bank_q);
    rd_bank         = BANK_W'(rd_bank_q);
    wr_addr         = {wr_bank, ADDR_W'(0)};
    wr_max_addr     = {wr_bank, ADDR_W'(FRAME_WORDS)};
    rd_addr         = {rd_bank, ADDR_W'(0)};
    rd_max_addr     = {rd_bank, ADDR_W'(FRAME_WORDS)};
    wr_busy         = f_wr.hit;
    frames_dropped  = drop_q;
    frames_repeated = rep_q;
    frames_aborted  = abort_q;
  end

endmodule
